// File: rtl/lod_16b_lut.sv
// 16-bit leading-one detector: flat priority lookup giving the leading-zero count
// and a valid flag combinationally, plus a one-cycle registered copy of both.
module lod_16b_lut (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  output logic [3:0]  out,
  output logic        vld,
  output logic [3:0]  out_q,
  output logic        vld_q
);

  // The first matching row wins, so all bits below the leading one are don't-care.
  // An all-zero word falls through to the default row: count 0 with vld low.
  // This matches a recursive 2-way leading-one tree, which also reports 0 for no set bit.
  always_comb begin
    out = 4'd0;
    vld = 1'b1;
    casez (in)
      16'b1???????????????: out = 4'd0;
      16'b01??????????????: out = 4'd1;
      16'b001?????????????: out = 4'd2;
      16'b0001????????????: out = 4'd3;
      16'b00001???????????: out = 4'd4;
      16'b000001??????????: out = 4'd5;
      16'b0000001?????????: out = 4'd6;
      16'b00000001????????: out = 4'd7;
      16'b000000001???????: out = 4'd8;
      16'b0000000001??????: out = 4'd9;
      16'b00000000001?????: out = 4'd10;
      16'b000000000001????: out = 4'd11;
      16'b0000000000001???: out = 4'd12;
      16'b00000000000001??: out = 4'd13;
      16'b000000000000001?: out = 4'd14;
      16'b0000000000000001: out = 4'd15;
      default: begin
        out = 4'd0;
        vld = 1'b0;
      end
    endcase
  end

  // The registered copy loads every cycle; there is no enable or handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 4'd0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out;
      vld_q <= vld;
    end
  end

endmodule

// File: tb/tb_lod_16b_lut.sv
// Bench for lod_16b_lut: vector table, one-hot walk, asynchronous reset sequence and
// an exhaustive sweep against a bit-scan reference model; registered outputs go through a queue.
module tb_lod_16b_lut;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic [3:0]  out;
  logic        vld;
  logic [3:0]  out_q;
  logic        vld_q;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];

  typedef struct {
    logic [15:0] din;
    logic [3:0]  eout;
    logic        evld;
  } vec_t;

  vec_t vecs[11];

  lod_16b_lut dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .out   (out),
    .vld   (vld),
    .out_q (out_q),
    .vld_q (vld_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan from bit 15 downward for the first set bit.
  function automatic logic [4:0] model(input logic [15:0] v);
    logic [3:0] c;
    for (int b = 15; b >= 0; b--) begin
      if (v[b]) begin
        c = 4'(15 - b);
        return {1'b1, c};
      end
    end
    return 5'd0;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one word between edges, check the combinational result at once and the
  // registered result just after the following rising edge.
  task automatic drive_cycle(input logic [15:0] v, input logic [3:0] eo, input logic ev);
    logic [4:0] e;
    @(negedge clk);
    in = v;
    #1;
    chk("comb_out", {12'd0, out}, {12'd0, eo});
    chk("comb_vld", {15'd0, vld}, {15'd0, ev});
    exp_q.push_back({ev, eo});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_underflow", 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      chk("reg_out", {12'd0, out_q}, {12'd0, e[3:0]});
      chk("reg_vld", {15'd0, vld_q}, {15'd0, e[4]});
    end
  endtask

  initial begin
    logic [15:0] v;
    logic [4:0]  m;

    vecs[0]  = '{16'hFFFF, 4'd0,  1'b1};
    vecs[1]  = '{16'h7FFF, 4'd1,  1'b1};
    vecs[2]  = '{16'h00FF, 4'd8,  1'b1};
    vecs[3]  = '{16'h0003, 4'd14, 1'b1};
    vecs[4]  = '{16'h0001, 4'd15, 1'b1};
    vecs[5]  = '{16'h0000, 4'd0,  1'b0};
    vecs[6]  = '{16'h8000, 4'd0,  1'b1};
    vecs[7]  = '{16'h0010, 4'd11, 1'b1};
    vecs[8]  = '{16'h0100, 4'd7,  1'b1};
    vecs[9]  = '{16'h1234, 4'd3,  1'b1};
    vecs[10] = '{16'h0800, 4'd4,  1'b1};

    // Reset with the walk's starting word already applied.
    rst_n = 1'b0;
    in    = 16'h8000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_q", {12'd0, out_q}, 16'd0);
    chk("reset_vld_q", {15'd0, vld_q}, 16'd0);
    chk("reset_comb_out", {12'd0, out}, 16'd0);
    chk("reset_comb_vld", {15'd0, vld}, 16'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // One-hot walk: rotate right each cycle, count steps 0..15 and wraps to 0.
    v = 16'h8000;
    for (int i = 0; i < 17; i++) begin
      drive_cycle(v, 4'(i % 16), 1'b1);
      v = {v[0], v[15:1]};
    end

    for (int i = 0; i < 11; i++)
      drive_cycle(vecs[i].din, vecs[i].eout, vecs[i].evld);

    // Asynchronous reset between edges.
    drive_cycle(16'h0010, 4'd11, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_q", {12'd0, out_q}, 16'd0);
    chk("async_rst_vld_q", {15'd0, vld_q}, 16'd0);
    chk("async_rst_comb_out", {12'd0, out}, 16'd11);
    chk("async_rst_comb_vld", {15'd0, vld}, 16'd1);
    @(posedge clk);
    #1;
    chk("held_rst_out_q", {12'd0, out_q}, 16'd0);
    chk("held_rst_vld_q", {15'd0, vld_q}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_q", {12'd0, out_q}, 16'd11);
    chk("post_rst_vld_q", {15'd0, vld_q}, 16'd1);

    // Exhaustive combinational sweep against the reference model.
    for (int i = 0; i < 65536; i++) begin
      in = 16'(i);
      #1;
      m = model(16'(i));
      chk("exh_out", {12'd0, out}, {12'd0, m[3:0]});
      chk("exh_vld", {15'd0, vld}, {15'd0, m[4]});
    end

    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lod_16b_lut.md
LOD_16B_LUT -- requirements
Module: lod_16b_lut

Interface
REQ-001 The block SHALL have no parameters; input width is fixed at 16 bits and count width at 4 bits.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in  input  16  data word to scan; bit 15 is the MSB.
REQ-005 out  output  4  combinational leading-zero count of in, i.e. the position of the leading one counted from bit 15.
REQ-006 vld  output  1  combinational; 1 when in contains at least one set bit.
REQ-007 out_q  output  4  out registered on clk.
REQ-008 vld_q  output  1  vld registered on clk.

Function
REQ-009 out SHALL equal 15 - p, where p is the index of the most significant set bit of in.
- in[15]=1 -> 0
- in = 16'h0001 -> 15
REQ-010 out SHALL depend only on the most significant set bit; all lower bits are don't-care (priority/casex decode).
REQ-011 For in = 16'h0000, out SHALL be 4'd0 and vld SHALL be 0.
REQ-012 The decode SHALL be a flat 16-entry priority lookup, not an adder or counter chain.
REQ-013 The decode SHALL be bit-identical to a recursive 2-way leading-one-detector tree for all 65536 inputs, including the all-zero case.
REQ-014 out and vld SHALL have zero-cycle latency: no clock involved, purely a function of the current in.
REQ-015 out_q and vld_q SHALL capture out and vld on every rising clk edge while rst_n=1, giving one cycle of latency.
REQ-016 No enable or handshake SHALL exist; the registers load unconditionally every cycle.
REQ-017 No X SHALL propagate to out or vld for any fully-known in.

Reset
REQ-018 While rst_n=0, out_q SHALL be 4'd0 and vld_q SHALL be 0, taking effect asynchronously without waiting for clk.
REQ-019 Reset SHALL NOT affect the combinational out or vld.
REQ-020 After rst_n rises, the first rising clk edge SHALL load out_q and vld_q from the current in.
REQ-021 Asserting reset mid-stream SHALL clear out_q and vld_q immediately.
REQ-022 After such a mid-stream reset, normal tracking SHALL resume on the first clk edge after release.

Verification
REQ-023 One-hot walk: load in=16'h8000 at reset, then rotate right one bit per cycle.
- out SHALL step 0,1,2,...,15, then wrap to 0.
- vld SHALL stay 1 throughout.
- out_q SHALL follow out one cycle later.
REQ-024 Don't-care lower bits: these inputs SHALL produce the listed out with vld=1.
- 16'hFFFF -> 0
- 16'h7FFF -> 1
- 16'h00FF -> 8
- 16'h0003 -> 14
- 16'h0001 -> 15
REQ-025 Zero input: in=16'h0000 SHALL give out=0 and vld=0; after one edge, out_q=0 and vld_q=0.
REQ-026 Asynchronous reset: with in=16'h0010 (out=11), pull rst_n low between clk edges.
- out_q and vld_q SHALL go to 0/0 before the next edge.
- After rst_n release, the next edge SHALL give out_q=11 and vld_q=1.
REQ-027 Exhaustive: for all 65536 values of in, out and vld SHALL match a reference model (leading-zero count, vld = |in), with zero mismatches.
